regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the pipelined MIPS datapath: NRD read ports, two write
//  ports (WB and late-ALU), same-cycle write-to-read bypass and a per-register busy scoreboard for
//  hazard detection. After reset a sweep FSM clears the array one entry per cycle; ready flags completion.
// PARAMETERS
//  DSIZE    16  data width (bits)
//  ASIZE    4   register address width
//  NREG     16  number of registers (<= 2**ASIZE)
//  NRD      2   number of read ports
//  ZERO_R0  1   1: register 0 reads as 0, writes/sets to it are dropped
// PORTS
//  clk      in   1            clock, all state on posedge
//  rst      in   1            asynchronous active-low reset (0 = reset)
//  ready    out  1            1 once init sweep done; 0 during reset and sweep
//  wen0     in   1            write enable, port 0
//  waddr0   in   ASIZE        write address, port 0
//  wdata0   in   DSIZE        write data, port 0
//  wen1     in   1            write enable, port 1 (priority over port 0)
//  waddr1   in   ASIZE        write address, port 1
//  wdata1   in   DSIZE        write data, port 1
//  set_en   in   1            mark register set_addr busy (producer issued)
//  set_addr in   ASIZE        register to mark busy
//  raddr    in   NRD*ASIZE    read addresses, port k at [k*ASIZE +: ASIZE]
//  rdata    out  NRD*DSIZE    read data, port k at [k*DSIZE +: DSIZE]
//  rbusy    out  NRD          busy flag for each read address
// BEHAVIOUR
//  Reset (rst=0, async): state<=INIT, ptr<=0, busy[] all 0, ready=0. Array is not async-reset.
//  FSM INIT: each cycle regdata[ptr]<=0, ptr<=ptr+1; at ptr==NREG-1 -> RUN. ready=1 from the
//   first RUN cycle, i.e. exactly NREG cycles after the first clk edge with rst=1.
//  INIT: wen0/wen1/set_en ignored; rdata forced 0, rbusy forced 0.
//  rst reasserted in any state: immediate return to INIT, ptr=0, sweep restarts fully.
//  RUN writes: posedge, wenN=1 -> regdata[waddrN]<=wdataN. waddr0==waddr1 with both wen: port 1
//   stored, port 0 dropped. Addresses >= NREG: write ignored, read returns 0, rbusy 0.
//  Reads: combinational. Read k = wdata1 if wen1 & waddr1==raddr_k; else wdata0 if
//   wen0 & waddr0==raddr_k; else regdata[raddr_k]. Zero latency, same-cycle bypass.
//  ZERO_R0=1: raddr_k==0 -> rdata 0, rbusy 0, no bypass; wen/set_en to addr 0 ignored.
//  Scoreboard (RUN): set_en sets busy[set_addr]; any enabled write clears busy[waddrN].
//   Set and clear on same register same cycle: set wins (newer producer outstanding).
//  rbusy_k = busy[raddr_k] & ~(same-cycle enabled write to raddr_k); a write clearing a busy
//   register lets the reader use the bypassed value in that cycle.
//  ready held 1 for the whole RUN state; only rst returns it to 0.
// TESTING
//  Reset, release, idle -> ready=0 for 16 cycles, 1 on cycle 16; all rdata read 0.
//  RUN: wen0 r3=0x1234, same cycle raddr0=3 -> rdata0=0x1234 (bypass); next cycle still 0x1234.
//  wen0 r5=0x00AA and wen1 r5=0x00BB same cycle -> bypass and stored value 0x00BB.
//  set_en r7; next cycle raddr1=7 -> rbusy[1]=1; wen1 r7=0x0042 -> rbusy[1]=0, rdata1=0x0042.
//  wen0 r0=0xFFFF, set_en r0 -> raddr0=0 reads 0x0000, rbusy 0; set_en r4 & wen0 r4 same cycle -> busy stays 1.
//  rst low mid-sweep (ptr=9) and mid-RUN -> ready 0 at once, busy cleared, full 16-cycle sweep again.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: two write ports, busy-set port, NRD flattened read ports, ready.
interface regfile_mp_if #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned ASIZE = 4,
  parameter int unsigned NRD   = 2
);
  logic                   ready;
  logic                   wen0;
  logic [ASIZE-1:0]       waddr0;
  logic [DSIZE-1:0]       wdata0;
  logic                   wen1;
  logic [ASIZE-1:0]       waddr1;
  logic [DSIZE-1:0]       wdata1;
  logic                   set_en;
  logic [ASIZE-1:0]       set_addr;
  logic [NRD*ASIZE-1:0]   raddr;
  logic [NRD*DSIZE-1:0]   rdata;
  logic [NRD-1:0]         rbusy;

  modport master (
    output wen0, waddr0, wdata0, wen1, waddr1, wdata1, set_en, set_addr, raddr,
    input  ready, rdata, rbusy
  );

  modport slave (
    input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, set_en, set_addr, raddr,
    output ready, rdata, rbusy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and post-reset clear sweep.
module regfile_mp #(
  parameter int unsigned DSIZE   = 16,
  parameter int unsigned ASIZE   = 4,
  parameter int unsigned NREG    = 16,
  parameter int unsigned NRD     = 2,
  parameter bit          ZERO_R0 = 1'b1
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);

  typedef enum logic {StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [ASIZE-1:0] ptr_q, ptr_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [DSIZE-1:0] mem_q [NREG];

  logic run, we0, we1, set_ok;

  // Address names a real, writable/readable register (r0 excluded when hard-wired).
  function automatic logic addr_ok(input logic [ASIZE-1:0] a);
    return (32'(a) < NREG) && !(ZERO_R0 && (a == '0));
  endfunction

  assign run    = (state_q == StRun);
  assign we0    = run & bus.wen0 & addr_ok(bus.waddr0);
  assign we1    = run & bus.wen1 & addr_ok(bus.waddr1);
  assign set_ok = run & bus.set_en & addr_ok(bus.set_addr);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ASIZE'(NREG - 1)) begin
          state_d = StRun;
          ptr_d   = '0;
        end
      end
      StRun: ;
    endcase
  end

  // Set is applied after clears so a newly issued producer stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (we0)    busy_d[bus.waddr0]   = 1'b0;
    if (we1)    busy_d[bus.waddr1]   = 1'b0;
    if (set_ok) busy_d[bus.set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Array carries no reset; the sweep clears it. Port 1 is written last so it wins on collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (we0) mem_q[bus.waddr0] <= bus.wdata0;
      if (we1) mem_q[bus.waddr1] <= bus.wdata1;
    end
  end

  assign bus.ready = run;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ASIZE-1:0] ra;
    logic             hit0, hit1;

    assign ra   = bus.raddr[k*ASIZE +: ASIZE];
    assign hit1 = we1 && (bus.waddr1 == ra);
    assign hit0 = we0 && (bus.waddr0 == ra);

    always_comb begin
      bus.rdata[k*DSIZE +: DSIZE] = '0;
      bus.rbusy[k]                = 1'b0;
      if (run && addr_ok(ra)) begin
        if (hit1)      bus.rdata[k*DSIZE +: DSIZE] = bus.wdata1;
        else if (hit0) bus.rdata[k*DSIZE +: DSIZE] = bus.wdata0;
        else           bus.rdata[k*DSIZE +: DSIZE] = mem_q[ra];
        bus.rbusy[k] = busy_q[ra] & ~(hit0 | hit1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed vectors queue expectations, a negedge monitor checks.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_mp_if #(.DSIZE(16), .ASIZE(4), .NRD(2)) bus ();

  regfile_mp #(
    .DSIZE  (16),
    .ASIZE  (4),
    .NREG   (16),
    .NRD    (2),
    .ZERO_R0(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic [1:0]  bz;
    logic        rdy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      if (bus.rdata !== {mon_e.rd1, mon_e.rd0} || bus.rbusy !== mon_e.bz ||
          bus.ready !== mon_e.rdy) begin
        n_miss++;
        $display("FAIL %s: got rdata0=%h rdata1=%h rbusy=%b ready=%b, want %h %h %b %b",
                 mon_e.name, bus.rdata[15:0], bus.rdata[31:16], bus.rbusy, bus.ready,
                 mon_e.rd0, mon_e.rd1, mon_e.bz, mon_e.rdy);
      end
    end
  end

  task automatic apply(input string nm,
                       input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                       input logic w1, input logic [3:0] a1, input logic [15:0] d1,
                       input logic se, input logic [3:0] sa,
                       input logic [3:0] r0, input logic [3:0] r1,
                       input logic [15:0] e0, input logic [15:0] e1,
                       input logic [1:0] eb, input logic er);
    exp_t e;
    @(posedge clk);
    #1;
    bus.wen0 = w0; bus.waddr0 = a0; bus.wdata0 = d0;
    bus.wen1 = w1; bus.waddr1 = a1; bus.wdata1 = d1;
    bus.set_en = se; bus.set_addr = sa;
    bus.raddr = {r1, r0};
    e.name = nm; e.rd0 = e0; e.rd1 = e1; e.bz = eb; e.rdy = er;
    sb_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [3:0] r0, input logic [3:0] r1,
                      input logic [15:0] e0, input logic [15:0] e1,
                      input logic [1:0] eb, input logic er);
    apply(nm, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, r0, r1, e0, e1, eb, er);
  endtask

  // ready must rise exactly on the 16th edge after reset release; reads stay 0 throughout.
  task automatic sweep_check(input string pfx);
    for (int i = 1; i <= 16; i++)
      idle($sformatf("%s_%0d", pfx, i), 4'd3, 4'd9, 16'h0, 16'h0, 2'b00, i == 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wen0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.wen1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.set_en = 1'b0; bus.set_addr = '0; bus.raddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    sweep_check("init");

    //    name          w0  a0     d0        w1  a1     d1        se  sa     r0     r1     e0        e1        eb     rdy
    apply("byp_r3",     1, 4'd3,  16'h1234, 0,  4'd0,  16'h0,    0,  4'd0,  4'd3,  4'd3,  16'h1234, 16'h1234, 2'b00, 1);
    idle ("hold_r3",                                                         4'd3,  4'd0,  16'h1234, 16'h0000, 2'b00, 1);
    apply("dual_r5",    1, 4'd5,  16'h00AA, 1,  4'd5,  16'h00BB, 0,  4'd0,  4'd5,  4'd3,  16'h00BB, 16'h1234, 2'b00, 1);
    idle ("store_r5",                                                        4'd5,  4'd5,  16'h00BB, 16'h00BB, 2'b00, 1);
    apply("set_r7",     0, 4'd0,  16'h0,    0,  4'd0,  16'h0,    1,  4'd7,  4'd0,  4'd7,  16'h0000, 16'h0000, 2'b00, 1);
    idle ("busy_r7",                                                         4'd0,  4'd7,  16'h0000, 16'h0000, 2'b10, 1);
    apply("clr_r7",     0, 4'd0,  16'h0,    1,  4'd7,  16'h0042, 0,  4'd0,  4'd0,  4'd7,  16'h0000, 16'h0042, 2'b00, 1);
    idle ("after_r7",                                                        4'd0,  4'd7,  16'h0000, 16'h0042, 2'b00, 1);
    apply("wr_r0",      1, 4'd0,  16'hFFFF, 0,  4'd0,  16'h0,    1,  4'd0,  4'd0,  4'd0,  16'h0000, 16'h0000, 2'b00, 1);
    idle ("read_r0",                                                         4'd0,  4'd7,  16'h0000, 16'h0042, 2'b00, 1);
    apply("setclr_r4",  1, 4'd4,  16'h1111, 0,  4'd0,  16'h0,    1,  4'd4,  4'd4,  4'd4,  16'h1111, 16'h1111, 2'b00, 1);
    idle ("busy_r4",                                                         4'd4,  4'd7,  16'h1111, 16'h0042, 2'b01, 1);
    apply("clrbyp_r4",  1, 4'd4,  16'h2222, 0,  4'd0,  16'h0,    0,  4'd0,  4'd4,  4'd4,  16'h2222, 16'h2222, 2'b00, 1);
    idle ("idle_r4",                                                         4'd4,  4'd4,  16'h2222, 16'h2222, 2'b00, 1);
    apply("set_r9",     0, 4'd0,  16'h0,    0,  4'd0,  16'h0,    1,  4'd9,  4'd9,  4'd3,  16'h0000, 16'h1234, 2'b00, 1);
    idle ("busy_r9",                                                         4'd9,  4'd3,  16'h0000, 16'h1234, 2'b01, 1);

    // Mid-RUN reset: asserted between edges, so outputs must drop before the next edge.
    idle("rst_run", 4'd9, 4'd3, 16'h0, 16'h0, 2'b00, 1'b0);
    #1 rst = 1'b0;
    idle("rst_run_hold", 4'd9, 4'd3, 16'h0, 16'h0, 2'b00, 1'b0);
    @(negedge clk); #2 rst = 1'b1;
    sweep_check("resweep");
    idle("post_rst", 4'd9, 4'd3, 16'h0, 16'h0, 2'b00, 1'b1);

    // Mid-sweep reset at ptr==9 must restart the full sweep.
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    for (int i = 1; i <= 9; i++)
      idle($sformatf("part_%0d", i), 4'd3, 4'd9, 16'h0, 16'h0, 2'b00, 1'b0);
    #1 rst = 1'b0;
    idle("rst_sweep_hold", 4'd3, 4'd9, 16'h0, 16'h0, 2'b00, 1'b0);
    @(negedge clk); #2 rst = 1'b1;
    sweep_check("restart");
    idle("post_sweep", 4'd5, 4'd7, 16'h0, 16'h0, 2'b00, 1'b1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
